// File: rtl/pe_array_ctrl.sv
// Tile sequencer for pe_array: clear, bias load, streamed MAC, capture, then
// serial readout of the PE psum chain toward the output writer.
module pe_array_ctrl #(
    parameter int N_PEs      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 32,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  vec_len,
    input  logic                  cfg_relu,
    input  logic                  cfg_sign,
    input  logic                  ia_in_valid,
    input  logic [DATA_WIDTH-1:0] ia_in,
    output logic                  ia_in_ready,
    input  logic [PSUM_WIDTH-1:0] pe_psum,
    output logic                  rst_pe_relu_reg,
    output logic                  load_bias,
    output logic                  load_psum,
    output logic                  shift,
    output logic                  sel_pe_reg,
    output logic [N_PEs-1:0]      wea_reg1,
    output logic [N_PEs-1:0]      wea_reg2,
    output logic [DATA_WIDTH-1:0] ia,
    output logic                  ia_sign,
    output logic                  if_relu,
    output logic                  out_valid,
    output logic [PSUM_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int DCW = $clog2(N_PEs + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_BIAS, S_MAC, S_FLUSH, S_CAPT, S_LOADP, S_DRAIN, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    acc_cnt_q;
    logic [DCW-1:0]          drn_cnt_q;
    logic                    relu_q, sign_q;
    logic [DATA_WIDTH-1:0]   ia_q;
    logic                    wea1_q;
    logic                    accept, hs;

    assign accept = (state_q == S_MAC) && ia_in_valid;
    assign hs     = (state_q == S_DRAIN) && out_ready;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLR;
            S_CLR:   state_d = S_BIAS;
            S_BIAS:  state_d = (len_q != '0) ? S_MAC : S_FLUSH;
            S_MAC:   if (accept && (acc_cnt_q == len_q - LEN_WIDTH'(1))) state_d = S_FLUSH;
            S_FLUSH: state_d = S_CAPT;
            S_CAPT:  state_d = S_LOADP;
            S_LOADP: state_d = S_DRAIN;
            S_DRAIN: if (hs && (drn_cnt_q == DCW'(N_PEs - 1))) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rst_pe_relu_reg = 1'b0;
        load_bias       = 1'b0;
        load_psum       = 1'b0;
        sel_pe_reg      = 1'b0;
        out_valid       = 1'b0;
        ia_in_ready     = 1'b0;
        done            = 1'b0;
        wea_reg2        = '0;
        case (state_q)
            S_CLR:   rst_pe_relu_reg = 1'b1;
            S_BIAS:  load_bias = 1'b1;
            S_MAC:   ia_in_ready = 1'b1;
            S_CAPT:  wea_reg2 = '1;
            S_LOADP: load_psum = 1'b1;
            S_DRAIN: begin
                sel_pe_reg = 1'b1;
                out_valid  = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
        shift    = hs;
        busy     = (state_q != S_IDLE);
        wea_reg1 = {N_PEs{wea1_q}};
        ia       = ia_q;
        ia_sign  = sign_q;
        if_relu  = relu_q;
        out_data = pe_psum;
    end

    // Tile config is captured once so the source may change it mid-tile.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q  <= '0;
            relu_q <= 1'b0;
            sign_q <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            len_q  <= vec_len;
            relu_q <= cfg_relu;
            sign_q <= cfg_sign;
        end
    end

    // Write enable lags the accept by one cycle so it lines up with the registered ia.
    always_ff @(posedge clk) begin
        if (reset) begin
            ia_q   <= '0;
            wea1_q <= 1'b0;
        end else begin
            wea1_q <= accept;
            if (accept) ia_q <= ia_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_cnt_q <= '0;
            drn_cnt_q <= '0;
        end else begin
            if (state_q == S_BIAS)   acc_cnt_q <= '0;
            else if (accept)         acc_cnt_q <= acc_cnt_q + LEN_WIDTH'(1);
            if (state_q == S_LOADP)  drn_cnt_q <= '0;
            else if (hs)             drn_cnt_q <= drn_cnt_q + DCW'(1);
        end
    end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Scoreboard bench for pe_array_ctrl with a behavioural PE psum chain.
module tb_pe_array_ctrl;
    localparam int N  = 16;
    localparam int DW = 8;
    localparam int PW = 32;
    localparam int LW = 12;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [LW-1:0] vec_len = '0;
    logic          cfg_relu = 1'b0, cfg_sign = 1'b0;
    logic          ia_in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] ia_in = '0;
    logic          ia_in_ready, rst_pe_relu_reg, load_bias, load_psum, shift, sel_pe_reg;
    logic [N-1:0]  wea_reg1, wea_reg2;
    logic [DW-1:0] ia;
    logic          ia_sign, if_relu, out_valid, busy, done;
    logic [PW-1:0] out_data, pe_psum;

    pe_array_ctrl #(.N_PEs(N), .DATA_WIDTH(DW), .PSUM_WIDTH(PW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .vec_len(vec_len),
        .cfg_relu(cfg_relu), .cfg_sign(cfg_sign),
        .ia_in_valid(ia_in_valid), .ia_in(ia_in), .ia_in_ready(ia_in_ready),
        .pe_psum(pe_psum), .rst_pe_relu_reg(rst_pe_relu_reg), .load_bias(load_bias),
        .load_psum(load_psum), .shift(shift), .sel_pe_reg(sel_pe_reg),
        .wea_reg1(wea_reg1), .wea_reg2(wea_reg2), .ia(ia), .ia_sign(ia_sign),
        .if_relu(if_relu), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, tile_id = 0;
    int n_wea1, n_wea2, n_ldp, n_bias, n_clr, n_shift, n_done, n_rdy, hs_cnt;
    logic [DW-1:0] ia_exp[$];
    logic [PW-1:0] out_exp[$];
    logic [PW-1:0] chain[N];
    logic          prev_stall = 1'b0;
    logic [PW-1:0] prev_data;
    logic [DW-1:0] e_ia;
    logic [PW-1:0] e_out;

    assign pe_psum = chain[0];

    function automatic logic [PW-1:0] psum_val(input int t, input int i);
        return PW'(32'hA000_0000) + PW'(t * 256 + i);
    endfunction

    // Behavioural PE chain: parallel load, then shift toward the head.
    always @(posedge clk) begin
        if (!reset) begin
            if (load_psum) begin
                for (int i = 0; i < N; i++) chain[i] <= psum_val(tile_id, i);
            end else if (shift) begin
                for (int i = 0; i < N - 1; i++) chain[i] <= chain[i+1];
                chain[N-1] <= '0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (wea_reg1 !== '0) begin
                n_wea1++;
                vectors++;
                if (ia_exp.size() == 0) begin
                    miscompares++;
                    $display("FAIL wea1_unexpected: wea_reg1=%h with no accepted word pending", wea_reg1);
                end else begin
                    e_ia = ia_exp.pop_front();
                    if (wea_reg1 !== '1 || ia !== e_ia) begin
                        miscompares++;
                        $display("FAIL wea1_ia_align: wea_reg1=%h ia=%h, required ffff/%h", wea_reg1, ia, e_ia);
                    end
                end
            end
            if (ia_in_valid && ia_in_ready) ia_exp.push_back(ia_in);
            if (ia_in_ready) n_rdy++;
            if (load_psum) begin
                n_ldp++;
                for (int i = 0; i < N; i++) out_exp.push_back(psum_val(tile_id, i));
            end
            if (wea_reg2 !== '0) n_wea2++;
            if (load_bias) n_bias++;
            if (rst_pe_relu_reg) n_clr++;
            if (shift) n_shift++;
            if (done) n_done++;
            vectors++;
            if (shift !== (out_valid && out_ready)) begin
                miscompares++;
                $display("FAIL shift_vs_handshake: shift=%b valid=%b ready=%b", shift, out_valid, out_ready);
            end
            if (prev_stall) begin
                vectors++;
                if (out_data !== prev_data) begin
                    miscompares++;
                    $display("FAIL out_data_hold: %h, required %h", out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                vectors++;
                if (out_exp.size() == 0) begin
                    miscompares++;
                    $display("FAIL drain_unexpected: out_data=%h with nothing expected", out_data);
                end else begin
                    e_out = out_exp.pop_front();
                    if (out_data !== e_out) begin
                        miscompares++;
                        $display("FAIL drain_word: out_data=%h, required %h", out_data, e_out);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic run_tile(input int len, input bit gaps, input bit stall,
                            input bit restart, input int abort_hs, output int lat);
        int cyc, stall_n;
        bit restarted, relu_s, sign_s;
        tile_id++;
        n_wea1 = 0; n_wea2 = 0; n_ldp = 0; n_bias = 0; n_clr = 0;
        n_shift = 0; n_done = 0; n_rdy = 0; hs_cnt = 0;
        relu_s = tile_id[0]; sign_s = ~tile_id[1];
        vec_len = LW'(len); cfg_relu = relu_s; cfg_sign = sign_s; start = 1'b1;
        ia_in_valid = 1'b1; ia_in = DW'($urandom); out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cfg_relu = ~relu_s; cfg_sign = ~sign_s; vec_len = LW'(7);
        cyc = 0; stall_n = 0; restarted = 0; lat = -1;
        vectors++;
        if ({busy, if_relu, ia_sign} !== {1'b1, relu_s, sign_s}) begin
            miscompares++;
            $display("FAIL start_latch: busy/relu/sign=%b%b%b, required 1%b%b", busy, if_relu, ia_sign, relu_s, sign_s);
        end
        while (cyc < 200) begin
            if (done === 1'b1) begin lat = cyc; break; end
            if (abort_hs >= 0 && hs_cnt == abort_hs) break;
            ia_in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ia_in = DW'($urandom);
            start = restart && !restarted && ia_in_ready;
            if (start) restarted = 1;
            out_ready = 1'b1;
            if (stall && hs_cnt >= 5 && stall_n < 3) begin out_ready = 1'b0; stall_n++; end
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0; out_ready = 1'b1;
        if (abort_hs < 0) begin
            vectors++;
            if (lat < 0) begin
                miscompares++;
                $display("FAIL tile_timeout: no done within %0d cycles (len %0d)", cyc, len);
            end else begin
                @(posedge clk); #1;
                vectors++;
                if ({done, busy} !== 2'b00 || n_done != 1) begin
                    miscompares++;
                    $display("FAIL done_pulse: done=%b busy=%b pulses=%0d, required 0 0 1", done, busy, n_done);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        reset = 1'b1; ia_in_valid = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            outs = 64'({rst_pe_relu_reg, load_bias, load_psum, shift, sel_pe_reg, wea_reg1, wea_reg2,
                        ia, ia_sign, if_relu, out_valid, ia_in_ready, busy, done});
            vectors++;
            if (outs !== '0) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: outputs=%h, required 0", c, outs);
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        run_tile(4, 0, 0, 0, -1, lat);
        vectors++;
        if (lat != 25) begin miscompares++; $display("FAIL basic_latency: %0d, required 25", lat); end
        vectors++;
        if ({n_clr, n_bias, n_wea1, n_wea2, n_ldp, n_shift, hs_cnt} != {32'd1, 32'd1, 32'd4, 32'd1, 32'd1, 32'd16, 32'd16}) begin
            miscompares++;
            $display("FAIL basic_counts: clr %0d bias %0d wea1 %0d wea2 %0d ldp %0d shift %0d hs %0d, required 1 1 4 1 1 16 16",
                     n_clr, n_bias, n_wea1, n_wea2, n_ldp, n_shift, hs_cnt);
        end
        vectors++;
        if (ia_exp.size() != 0 || out_exp.size() != 0) begin
            miscompares++;
            $display("FAIL basic_leftover: ia %0d psum %0d, required 0 0", ia_exp.size(), out_exp.size());
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_tile(4, 1, 1, 0, -1, lat);
        vectors++;
        if (n_wea1 != 4 || hs_cnt != 16 || n_shift != 16) begin
            miscompares++;
            $display("FAIL bp_counts: wea1 %0d hs %0d shift %0d, required 4 16 16", n_wea1, hs_cnt, n_shift);
        end
        vectors++;
        if (ia_exp.size() != 0 || out_exp.size() != 0) begin
            miscompares++;
            $display("FAIL bp_leftover: ia %0d psum %0d, required 0 0", ia_exp.size(), out_exp.size());
        end
    endtask

    task automatic test_zero_len();
        int lat;
        run_tile(0, 0, 0, 0, -1, lat);
        vectors++;
        if (lat != 21) begin miscompares++; $display("FAIL zero_latency: %0d, required 21", lat); end
        vectors++;
        if (n_rdy != 0 || n_wea1 != 0 || hs_cnt != 16) begin
            miscompares++;
            $display("FAIL zero_counts: ready %0d wea1 %0d hs %0d, required 0 0 16", n_rdy, n_wea1, hs_cnt);
        end
    endtask

    task automatic test_start_busy();
        int lat;
        run_tile(4, 0, 0, 1, -1, lat);
        vectors++;
        if (lat != 25) begin miscompares++; $display("FAIL restart_latency: %0d, required 25", lat); end
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (n_done != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_ignored: done pulses %0d busy %b, required 1 0", n_done, busy);
        end
    endtask

    task automatic test_reset_mid_drain();
        int lat;
        logic [63:0] outs;
        run_tile(4, 0, 0, 0, 5, lat);
        vectors++;
        if (hs_cnt != 5 || n_shift != 5) begin
            miscompares++;
            $display("FAIL abort_point: hs %0d shift %0d, required 5 5", hs_cnt, n_shift);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        outs = 64'({rst_pe_relu_reg, load_bias, load_psum, shift, sel_pe_reg, wea_reg1, wea_reg2,
                    ia, ia_sign, if_relu, out_valid, ia_in_ready, busy, done});
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL abort_outputs: %h, required 0", outs);
        end
        reset = 1'b0;
        ia_exp.delete(); out_exp.delete();
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (n_done != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_done: done pulses %0d busy %b, required 0 0", n_done, busy);
        end
        run_tile(2, 0, 0, 0, -1, lat);
        vectors++;
        if (lat != 23 || hs_cnt != 16 || n_wea1 != 2) begin
            miscompares++;
            $display("FAIL after_abort_tile: lat %0d hs %0d wea1 %0d, required 23 16 2", lat, hs_cnt, n_wea1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_start_busy();
        test_reset_mid_drain();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pe_array_ctrl.md
# pe_array_ctrl

Sequencer for the `pe_array` datapath: runs one output tile per `start` pulse through clear, bias load, a streamed multiply-accumulate pass, capture, and serial readout of the PE chain. It sits between the activation buffer (valid/ready source of `ia` words) and the output writer (valid/ready sink of psums). It drives every control input of `pe_array` except `wgt` and `bias`, which the weight/bias fetch path supplies.

## Interface
- `N_PEs`, 16, PEs in the array; one output word per PE.
- `DATA_WIDTH`, 8, activation width.
- `PSUM_WIDTH`, 32, psum width.
- `LEN_WIDTH`, 12, width of the vector-length field.

Reset and clock are fixed for this block: one clock; reset is synchronous and active-high.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a tile; sampled only in IDLE.
- `vec_len`  in  LEN_WIDTH  number of `ia` words to accumulate; latched on start.
- `cfg_relu`, `cfg_sign`  in  1 each  latched on start; driven to `if_relu` and `ia_sign`.
- `ia_in_valid`  in  1  source word valid.
- `ia_in`  in  DATA_WIDTH  source word.
- `ia_in_ready`  out  1  accepting `ia_in`.
- `pe_psum`  in  PSUM_WIDTH  `psum_out` of the array.
- `rst_pe_relu_reg`, `load_bias`, `load_psum`, `shift`, `sel_pe_reg`  out  1 each  array controls.
- `wea_reg1`, `wea_reg2`  out  N_PEs each  per-PE write enables.
- `ia`  out  DATA_WIDTH  registered activation to the array.
- `ia_sign`, `if_relu`  out  1 each  latched config.
- `out_valid`  out  1  psum word valid.
- `out_data`  out  PSUM_WIDTH  equals `pe_psum`.
- `out_ready`  in  1  sink accepts.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the tile finishes.

## Operation
- States: IDLE, CLR, BIAS, MAC, FLUSH, CAPT, LOADP, DRAIN, DONE.
- IDLE: when `start` is high, latch `vec_len`, `cfg_relu` and `cfg_sign`, then go to CLR.
- CLR: `rst_pe_relu_reg` = 1 for one cycle, then BIAS.
- BIAS: `load_bias` = 1 for one cycle. Go to MAC if latched length is nonzero, otherwise FLUSH.
- MAC:
  - `ia_in_ready` = 1.
  - Each accepted word (valid && ready) is registered into `ia`, and `wea_reg1` = all ones on the following cycle, so the enable stays aligned with `ia`.
  - A cycle with no accepted word gives `wea_reg1` = 0 on the following cycle.
  - An accept counter (LEN_WIDTH) increments per accept. The cycle of the vec_len-th accept goes to FLUSH; `ia_in_ready` is 0 from FLUSH onward.
- FLUSH: one cycle that carries the last delayed `wea_reg1` pulse, then CAPT.
- CAPT: `wea_reg2` = all ones for one cycle, then LOADP.
- LOADP: `load_psum` = 1 for one cycle, then DRAIN.
- DRAIN:
  - `sel_pe_reg` = 1 and `out_valid` = 1.
  - On each handshake (`out_valid` && `out_ready`), `shift` = 1 that same cycle and a drain counter increments.
  - After the N_PEs-th handshake, go to DONE.
  - `out_ready` low means hold: no shift and `out_data` stable.
- DONE: `done` = 1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. No queueing.
- `ia_in` words offered outside MAC are not consumed.

## Timing
- Reset values: all outputs 0 (enables, pulses, `ia`, `busy`, `done`, `out_valid`, `ia_in_ready`). State goes to IDLE and counters clear.
- Reset asserted in any state aborts the tile the next edge: outputs 0 and no `done`. The counters and latched config are discarded.
- `busy` rises the cycle after `start` is sampled.
- Minimum tile latency (start sampled to `done` high), with continuous `ia_in_valid` and `out_ready`: 5 + vec_len + N_PEs cycles.
- `vec_len` = 0 gives BIAS→FLUSH, and `wea_reg1` never asserts.
- `out_data` is combinational from `pe_psum`. The first DRAIN word is the PE chain head after LOADP.
- All one-hot pulses (`rst_pe_relu_reg`, `load_bias`, `load_psum`, `wea_reg2`, `done`) are exactly one cycle wide.
- Max vec_len is 2^LEN_WIDTH−1. The counter never wraps within a tile.

## Test plan
- Reset/idle: hold `reset` 3 cycles, then idle 5 → all outputs 0, `busy` = 0, `ia_in_ready` = 0.
- Basic tile: N_PEs = 16, vec_len = 4, continuous valid/ready → CLR, BIAS, four `wea_reg1` pulses aligned to `ia`, one `wea_reg2`, one `load_psum`, 16 `shift`s, `done` at cycle 25 after start.
- Backpressure: random `ia_in_valid` gaps plus `out_ready` low for 3 cycles mid-drain →
  - `wea_reg1` exactly 4 times;
  - no shift while `out_ready` = 0;
  - `out_data` stable;
  - 16 handshakes total.
- Zero length: vec_len = 0 → no `ia_in_ready`, no `wea_reg1`, `done` at cycle 21.
- Start while busy: second `start` during MAC → ignored; exactly one `done`.
- Reset mid-drain: assert `reset` after the 5th shift → next cycle all outputs 0, IDLE, no `done`. A following tile with vec_len = 2 completes normally.
